// File: rtl/button_defs.sv
// Shared button and event encodings for the resolver, event generator and UI FSM.
package button_defs;

  localparam logic [3:0] BTN_0     = 4'd0;
  localparam logic [3:0] BTN_1     = 4'd1;
  localparam logic [3:0] BTN_2     = 4'd2;
  localparam logic [3:0] BTN_3     = 4'd3;
  localparam logic [3:0] BTN_ENTER = 4'd4;
  localparam logic [3:0] BTN_LEFT  = 4'd5;
  localparam logic [3:0] BTN_RIGHT = 4'd6;
  localparam logic [3:0] BTN_UP    = 4'd7;
  localparam logic [3:0] BTN_DOWN  = 4'd8;

  localparam int NUM_BUTTONS = 9;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_REPEAT  = 2'd1;
  localparam logic [1:0] EVT_RELEASE = 2'd2;

  // Auto-repeat timing for the 27 MHz board clock: 0.5 s initial delay, 0.1 s period.
  localparam int CLK_HZ                = 27_000_000;
  localparam int HOLD_DELAY_DEFAULT    = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } btn_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_fifo.sv
// First-word-fall-through event queue with a sticky overflow flag for dropped pushes.
module button_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf_q;
  logic             do_push, do_pop, drop;

  assign valid    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign overflow = ovf_q;

  // A pop on an empty queue is ignored, so a simultaneous push just lands.
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // behind the count, and the head is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/button_event_generator.sv
// Turns resolved button lines into PRESS / REPEAT / RELEASE events queued for the UI FSM.
module button_event_generator
  import button_defs::*;
#(
  parameter int HOLD_DELAY    = HOLD_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button0_in,
  input  logic       button1_in,
  input  logic       button2_in,
  input  logic       button3_in,
  input  logic       button_enter_in,
  input  logic       button_left_in,
  input  logic       button_right_in,
  input  logic       button_up_in,
  input  logic       button_down_in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [3:0] event_code,
  output logic [1:0] event_type,
  output logic       button_held,
  output logic       overflow
);

  localparam int CNT_W = $clog2(max_int(HOLD_DELAY, REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] btn_vec;
  logic                   one_hot;
  logic [3:0]             enc_code;

  btn_state_t             state_q, state_d;
  logic [3:0]             code_q, code_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   push;
  logic [3:0]             push_code;
  logic [1:0]             push_type;
  logic [5:0]             fifo_dout;
  logic                   fifo_full;

  // Bit position equals the button code.
  assign btn_vec = {button_down_in, button_up_in, button_right_in, button_left_in,
                    button_enter_in, button3_in, button2_in, button1_in, button0_in};
  assign one_hot = $onehot(btn_vec);

  always_comb begin
    enc_code = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (btn_vec[i]) enc_code = 4'(i);
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_code = code_q;
    push_type = EVT_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (one_hot) begin
          code_d    = enc_code;
          push      = 1'b1;
          push_code = enc_code;
          push_type = EVT_PRESS;
          cnt_d     = HOLD_LOAD;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!btn_vec[code_q]) begin
          push      = 1'b1;
          push_type = EVT_RELEASE;
          state_d   = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (REPEAT_EN) begin
          push      = 1'b1;
          push_type = EVT_REPEAT;
          cnt_d     = REPEAT_LOAD;
          state_d   = ST_REPEAT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign button_held = (state_q != ST_IDLE);

  button_event_fifo #(
    .WIDTH(6),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .din      ({push_code, push_type}),
    .full     (fifo_full),
    .pop      (event_ready),
    .dout     (fifo_dout),
    .valid    (event_valid),
    .overflow (overflow)
  );

  assign event_code = fifo_dout[5:2];
  assign event_type = fifo_dout[1:0];

endmodule

// File: tb/tb_button_event_generator.sv
// Directed bench for button_event_generator with short hold/repeat timing.
module tb_button_event_generator;

  localparam logic [8:0] B0   = 9'h001;
  localparam logic [8:0] B1   = 9'h002;
  localparam logic [8:0] B2   = 9'h004;
  localparam logic [8:0] B3   = 9'h008;
  localparam logic [8:0] BENT = 9'h010;
  localparam logic [8:0] BUP  = 9'h080;
  localparam logic [8:0] BDN  = 9'h100;
  localparam logic [1:0] P    = 2'd0;
  localparam logic [1:0] RP   = 2'd1;
  localparam logic [1:0] RL   = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       button0_in, button1_in, button2_in, button3_in;
  logic       button_enter_in, button_left_in, button_right_in, button_up_in, button_down_in;
  logic       event_valid, event_ready;
  logic [3:0] event_code;
  logic [1:0] event_type;
  logic       button_held, overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] btn;
    logic       ready;
    logic       valid;
    logic [3:0] code;
    logic [1:0] etype;
    logic       held;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  button_event_generator #(
    .HOLD_DELAY(8),
    .REPEAT_PERIOD(4),
    .REPEAT_EN(1'b1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .button0_in      (button0_in),
    .button1_in      (button1_in),
    .button2_in      (button2_in),
    .button3_in      (button3_in),
    .button_enter_in (button_enter_in),
    .button_left_in  (button_left_in),
    .button_right_in (button_right_in),
    .button_up_in    (button_up_in),
    .button_down_in  (button_down_in),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_code      (event_code),
    .event_type      (event_type),
    .button_held     (button_held),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [3:0] c,
                            input logic [1:0] t, input logic h, input logic o);
    check({tag, ".valid"}, 32'(event_valid), 32'(v));
    check({tag, ".code"},  32'(event_code),  32'(c));
    check({tag, ".type"},  32'(event_type),  32'(t));
    check({tag, ".held"},  32'(button_held), 32'(h));
    check({tag, ".ovf"},   32'(overflow),    32'(o));
  endtask

  task automatic set_btn(input logic [8:0] b);
    {button_down_in, button_up_in, button_right_in, button_left_in, button_enter_in,
     button3_in, button2_in, button1_in, button0_in} = b;
  endtask

  // One clock: inputs already applied, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [8:0] b, input logic r, input logic v,
                              input logic [3:0] c, input logic [1:0] t,
                              input logic h, input logic o);
    vec_t e;
    e.btn = b; e.ready = r; e.valid = v; e.code = c; e.etype = t; e.held = h; e.ovf = o;
    vecs.push_back(e);
  endfunction

  initial begin
    // Enter tapped for one cycle: PRESS, then RELEASE, held for exactly one cycle.
    add(BENT, 1, 1, 4'd4, P,  1, 0);
    add(9'h0, 1, 1, 4'd4, RL, 0, 0);
    add(9'h0, 1, 0, 4'd0, P,  0, 0);
    // Two buttons at once is illegal: nothing happens.
    for (int i = 0; i < 5; i++) add(B1 | B3, 1, 0, 4'd0, P, 0, 0);
    add(9'h0, 1, 0, 4'd0, P, 0, 0);
    // Up held for 18 edges: PRESS at 0, REPEAT at 8/12/16, RELEASE at 18.
    for (int i = 0; i < 20; i++) begin
      logic       v;
      logic [1:0] t;
      v = 1'b0;
      t = P;
      if (i == 0) v = 1'b1;
      else if (i >= 8 && i < 18 && ((i - 8) % 4) == 0) begin v = 1'b1; t = RP; end
      else if (i == 18) begin v = 1'b1; t = RL; end
      add((i < 18) ? BUP : 9'h0, 1, v, v ? 4'd7 : 4'd0, t, (i < 18) ? 1'b1 : 1'b0, 0);
    end
    // Consumer stalled: four events fit, the fifth and sixth are dropped.
    add(B0,   0, 1, 4'd0, P,  1, 0);
    add(9'h0, 0, 1, 4'd0, P,  0, 0);
    add(B1,   0, 1, 4'd0, P,  1, 0);
    add(9'h0, 0, 1, 4'd0, P,  0, 0);
    add(B2,   0, 1, 4'd0, P,  1, 1);
    add(9'h0, 0, 1, 4'd0, P,  0, 1);
    add(9'h0, 1, 1, 4'd0, RL, 0, 1);
    add(9'h0, 1, 1, 4'd1, P,  0, 1);
    add(9'h0, 1, 1, 4'd1, RL, 0, 1);
    add(9'h0, 1, 0, 4'd0, P,  0, 1);
    add(9'h0, 1, 0, 4'd0, P,  0, 1);

    reset = 1'b1;
    event_ready = 1'b1;
    set_btn(9'h0);
    step();
    step();
    check_outs("reset", 0, 4'd0, P, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      set_btn(vecs[i].btn);
      event_ready = vecs[i].ready;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code,
                 vecs[i].etype, vecs[i].held, vecs[i].ovf);
    end

    // Asynchronous reset while down is held mid-HOLD; no RELEASE, fresh PRESS afterwards.
    set_btn(BDN);
    event_ready = 1'b1;
    step();
    check_outs("rst_press", 1, 4'd8, P, 1, 1);
    step();
    step();
    check_outs("rst_hold", 0, 4'd0, P, 1, 1);
    reset = 1'b1;
    #1;
    check_outs("rst_async", 0, 4'd0, P, 0, 0);
    step();
    check_outs("rst_during", 0, 4'd0, P, 0, 0);
    reset = 1'b0;
    step();
    check_outs("rst_repress", 1, 4'd8, P, 1, 0);
    set_btn(9'h0);
    step();
    check_outs("rst_release", 1, 4'd8, RL, 0, 0);
    step();
    check_outs("rst_empty", 0, 4'd0, P, 0, 0);

    // Fill the queue (P2, R2, P1, REPEAT1), then RELEASE arrives in the cycle the head pops.
    event_ready = 1'b0;
    set_btn(B2);
    step();
    check_outs("full_p2", 1, 4'd2, P, 1, 0);
    set_btn(9'h0);
    step();
    check_outs("full_r2", 1, 4'd2, P, 0, 0);
    set_btn(B1);
    repeat (8) step();
    check_outs("full_hold", 1, 4'd2, P, 1, 0);
    step();
    check_outs("full_rep", 1, 4'd2, P, 1, 0);
    set_btn(9'h0);
    event_ready = 1'b1;
    step();
    check_outs("full_swap", 1, 4'd2, RL, 0, 0);
    step();
    check_outs("drain_p1", 1, 4'd1, P, 0, 0);
    step();
    check_outs("drain_rep1", 1, 4'd1, RP, 0, 0);
    step();
    check_outs("drain_r1", 1, 4'd1, RL, 0, 0);
    step();
    check_outs("drain_empty", 0, 4'd0, P, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
